// File: rtl/bp_be_pkg.sv
// Shared definitions for the back-end trace replay checker.
// Holds the FSM state encoding and the sticky error codes.
package bp_be_pkg;

    typedef enum logic [2:0] {
        e_reset = 3'd0,
        e_prime = 3'd1,
        e_run   = 3'd2,
        e_done  = 3'd3,
        e_error = 3'd4
    } bp_be_trace_chk_state_e;

    localparam logic [1:0] err_none_c     = 2'b00;
    localparam logic [1:0] err_mismatch_c = 2'b01;
    localparam logic [1:0] err_overflow_c = 2'b10;

endpackage

// File: rtl/bp_be_trace_replay_checker.sv
// Compares committed trace packets against an external expected-trace ROM,
// one packet per cycle, and reports done, mismatch or ROM-index overflow.
module bp_be_trace_replay_checker
    import bp_be_pkg::*;
#(
    parameter int trace_ring_width_p = 129,
    parameter int rom_addr_width_p   = 10
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [trace_ring_width_p-1:0] data_i,
    input  logic                          v_i,
    output logic                          ready_o,
    output logic [rom_addr_width_p-1:0]   rom_addr_o,
    input  logic [trace_ring_width_p:0]   rom_data_i,
    output logic                          done_o,
    output logic                          error_o,
    output logic [1:0]                    err_code_o,
    output logic [rom_addr_width_p-1:0]   count_o,
    output logic [trace_ring_width_p-1:0] err_data_o
);

    localparam logic [rom_addr_width_p-1:0] ptr_max_lp = '1;

    bp_be_trace_chk_state_e          state_r;
    logic [rom_addr_width_p-1:0]     ptr_r;
    logic [1:0]                      err_code_r;
    logic [trace_ring_width_p-1:0]   err_data_r;

    logic                            eot;
    logic [trace_ring_width_p-1:0]   expected;
    logic                            accept;
    logic                            run_accept;
    logic                            match;

    assign eot      = rom_data_i[trace_ring_width_p];
    assign expected = rom_data_i[trace_ring_width_p-1:0];

    // Once past priming the checker always drains its input, even after finishing.
    assign ready_o    = (state_r == e_run) || (state_r == e_done) || (state_r == e_error);
    assign accept     = v_i & ready_o;
    assign run_accept = accept && (state_r == e_run);
    assign match      = (data_i == expected);

    // Look ahead one entry on accept so the ROM's one-cycle latency never stalls the stream.
    assign rom_addr_o = run_accept ? ptr_r + 1'b1 : ptr_r;

    assign done_o     = (state_r == e_done) || ((state_r == e_run) && eot);
    assign error_o    = (state_r == e_error);
    assign err_code_o = err_code_r;
    assign err_data_o = err_data_r;
    assign count_o    = ptr_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= e_reset;
            ptr_r      <= '0;
            err_code_r <= err_none_c;
            err_data_r <= '0;
        end else begin
            unique case (state_r)
                e_reset: state_r <= e_prime;
                e_prime: state_r <= e_run;
                e_run: begin
                    if (eot) begin
                        state_r <= e_done;
                    end else if (accept) begin
                        if (!match) begin
                            state_r    <= e_error;
                            err_code_r <= err_mismatch_c;
                            err_data_r <= data_i;
                        end else if (ptr_r == ptr_max_lp) begin
                            // Pointer saturates so count_o still names the failing entry.
                            state_r    <= e_error;
                            err_code_r <= err_overflow_c;
                        end else begin
                            ptr_r <= ptr_r + 1'b1;
                        end
                    end
                end
                e_done:  state_r <= e_done;
                e_error: state_r <= e_error;
                default: state_r <= e_reset;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_be_trace_replay_checker.sv
// Bench for the trace replay checker: two instances (wide and 2-bit ROM index)
// share one packet stream and are compared against a cycle-level reference model.
module tb_bp_be_trace_replay_checker;

    localparam int W = 129;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [W-1:0]  data;
    logic          v;

    logic          ready_a, ready_b, done_a, done_b, error_a, error_b;
    logic [9:0]    addr_a, count_a;
    logic [1:0]    addr_b, count_b, code_a, code_b;
    logic [W:0]    rdata_a, rdata_b;
    logic [W-1:0]  errdata_a, errdata_b;

    logic [W:0]    rom_mem [0:1023];

    bp_be_trace_replay_checker #(.trace_ring_width_p(W), .rom_addr_width_p(10)) dut_a (
        .clk_i(clk), .reset_n_i(reset_n), .data_i(data), .v_i(v), .ready_o(ready_a),
        .rom_addr_o(addr_a), .rom_data_i(rdata_a), .done_o(done_a), .error_o(error_a),
        .err_code_o(code_a), .count_o(count_a), .err_data_o(errdata_a)
    );

    bp_be_trace_replay_checker #(.trace_ring_width_p(W), .rom_addr_width_p(2)) dut_b (
        .clk_i(clk), .reset_n_i(reset_n), .data_i(data), .v_i(v), .ready_o(ready_b),
        .rom_addr_o(addr_b), .rom_data_i(rdata_b), .done_o(done_b), .error_o(error_b),
        .err_code_o(code_b), .count_o(count_b), .err_data_o(errdata_b)
    );

    // External ROMs: one cycle read latency.
    always @(posedge clk) begin
        rdata_a <= rom_mem[addr_a];
        rdata_b <= rom_mem[{8'd0, addr_b}];
    end

    logic          o_ready [2];
    logic          o_done  [2];
    logic          o_error [2];
    logic [1:0]    o_code  [2];
    logic [9:0]    o_addr  [2];
    logic [9:0]    o_count [2];
    logic [W-1:0]  o_errd  [2];

    assign o_ready[0] = ready_a;  assign o_ready[1] = ready_b;
    assign o_done[0]  = done_a;   assign o_done[1]  = done_b;
    assign o_error[0] = error_a;  assign o_error[1] = error_b;
    assign o_code[0]  = code_a;   assign o_code[1]  = code_b;
    assign o_addr[0]  = addr_a;   assign o_addr[1]  = {8'd0, addr_b};
    assign o_count[0] = count_a;  assign o_count[1] = {8'd0, count_b};
    assign o_errd[0]  = errdata_a; assign o_errd[1] = errdata_b;

    // Reference model: phase 0 reset, 1 prime, 2 checking, 3 finished, 4 failed.
    int           m_phase [2];
    int           m_ptr   [2];
    int           m_code  [2];
    logic [W-1:0] m_errd  [2];
    int           m_max   [2];
    int           total = 0;
    int           bad   = 0;

    task automatic chk(input string tag, input int idx, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_pkt();
        logic [W-1:0] p;
        if ($urandom_range(0, 1) == 1)
            p = {1'b1, $urandom, $urandom, $urandom, $urandom};
        else
            p = {1'b0, 59'd0, 5'($urandom_range(0, 31)), $urandom, $urandom};
        return p;
    endfunction

    function automatic logic [W-1:0] reg_pkt();
        return {1'b0, 59'd0, 5'($urandom_range(0, 31)), $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0;
            m_ptr[i]   = 0;
            m_code[i]  = 0;
            m_errd[i]  = '0;
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_ready"}, i, W'(o_ready[i]), '0);
            chk({tag, "_addr"},  i, W'(o_addr[i]),  '0);
            chk({tag, "_count"}, i, W'(o_count[i]), '0);
            chk({tag, "_done"},  i, W'(o_done[i]),  '0);
            chk({tag, "_error"}, i, W'(o_error[i]), '0);
            chk({tag, "_code"},  i, W'(o_code[i]),  '0);
            chk({tag, "_errd"},  i, o_errd[i],      '0);
        end
    endtask

    // Asynchronous assertion, taken mid-cycle.
    task automatic assert_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic load_trace(input int n, input logic with_eot);
        for (int k = 0; k < 1024; k++) rom_mem[k] = '0;
        for (int k = 0; k < n; k++) rom_mem[k] = {1'b0, rand_pkt()};
        rom_mem[n] = with_eot ? {1'b1, {W{1'b0}}} : {1'b0, rand_pkt()};
    endtask

    task automatic step(input logic vv, input logic [W-1:0] dd);
        logic [9:0] ea;
        logic       acc;
        @(negedge clk);
        v    = vv;
        data = dd;
        #1;
        for (int i = 0; i < 2; i++) begin
            acc = vv && (m_phase[i] >= 2);
            ea  = 10'(((m_phase[i] == 2 && acc) ? m_ptr[i] + 1 : m_ptr[i]) & m_max[i]);
            chk("ready", i, W'(m_phase[i] >= 2), W'(o_ready[i]) ^ '0 ^ W'(o_ready[i]) ^ W'(o_ready[i]));
            chk("rom_addr", i, W'(o_addr[i]), W'(ea));
            chk("done", i, W'(o_done[i]),
                W'(m_phase[i] == 3 || (m_phase[i] == 2 && rom_mem[m_ptr[i]][W])));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            case (m_phase[i])
                0: m_phase[i] = 1;
                1: m_phase[i] = 2;
                2: begin
                    if (rom_mem[m_ptr[i]][W]) begin
                        m_phase[i] = 3;
                    end else if (vv) begin
                        if (dd === rom_mem[m_ptr[i]][W-1:0]) begin
                            if (m_ptr[i] == m_max[i]) begin
                                m_phase[i] = 4;
                                m_code[i]  = 2;
                            end else begin
                                m_ptr[i]++;
                            end
                        end else begin
                            m_phase[i] = 4;
                            m_code[i]  = 1;
                            m_errd[i]  = dd;
                        end
                    end
                end
                default: ;
            endcase
            chk("count", i, W'(o_count[i]), W'(m_ptr[i]));
            chk("error", i, W'(o_error[i]), W'(m_phase[i] == 4));
            chk("err_code", i, W'(o_code[i]), W'(m_code[i]));
            chk("err_data", i, o_errd[i], m_errd[i]);
        end
    endtask

    initial begin
        m_max[0] = 1023;
        m_max[1] = 3;
        reset_n  = 1'b0;
        v        = 1'b1;
        data     = rand_pkt();
        for (int k = 0; k < 1024; k++) rom_mem[k] = '0;

        // Three register writes then eot; v held high through reset and priming.
        load_trace(0, 1'b0);
        for (int k = 0; k < 3; k++) rom_mem[k] = {1'b0, reg_pkt()};
        rom_mem[3] = {1'b1, {W{1'b0}}};
        assert_reset("rst0");
        step(1'b1, rand_pkt());
        step(1'b1, rand_pkt());
        for (int k = 0; k < 3; k++) step(1'b1, rom_mem[k][W-1:0]);
        step(1'b0, rand_pkt());
        step(1'b1, rand_pkt());

        // Store mismatch on the second packet.
        load_trace(0, 1'b0);
        rom_mem[0] = {1'b0, reg_pkt()};
        rom_mem[1] = {1'b0, 1'b1, 64'h8000_0000, 64'hDEAD};
        rom_mem[2] = {1'b1, {W{1'b0}}};
        assert_reset("rst1");
        step(1'b1, rand_pkt());
        step(1'b1, rand_pkt());
        step(1'b1, rom_mem[0][W-1:0]);
        step(1'b1, {1'b1, 64'h8000_0000, 64'hBEEF});
        step(1'b1, rom_mem[1][W-1:0]);
        step(1'b0, rand_pkt());

        // Valid toggling over four matching entries.
        load_trace(4, 1'b1);
        assert_reset("rst2");
        step(1'b0, rand_pkt());
        step(1'b0, rand_pkt());
        for (int k = 0; k < 8; k++) step(k % 2 == 0, (k % 2 == 0) ? rom_mem[k / 2][W-1:0] : rand_pkt());
        step(1'b0, rand_pkt());

        // No eot: the 2-bit instance overflows on its fourth match.
        load_trace(4, 1'b0);
        assert_reset("rst3");
        step(1'b0, rand_pkt());
        step(1'b0, rand_pkt());
        for (int k = 0; k < 5; k++) step(1'b1, rom_mem[k][W-1:0]);

        // Reset mid-run after two matches, then replay from entry 0.
        load_trace(3, 1'b1);
        assert_reset("rst4");
        step(1'b0, rand_pkt());
        step(1'b0, rand_pkt());
        step(1'b1, rom_mem[0][W-1:0]);
        step(1'b1, rom_mem[1][W-1:0]);
        assert_reset("rst_mid");
        step(1'b1, rand_pkt());
        step(1'b1, rand_pkt());
        for (int k = 0; k < 3; k++) step(1'b1, rom_mem[k][W-1:0]);
        step(1'b1, rand_pkt());

        // Randomised traces with random valid gaps and occasional corruption.
        for (int t = 0; t < 8; t++) begin
            load_trace($urandom_range(1, 6), 1'b1);
            assert_reset("rst_rand");
            step(1'b1, rand_pkt());
            step(1'b1, rand_pkt());
            for (int k = 0; k < 14; k++) begin
                if ($urandom_range(0, 11) == 0)
                    step(1'b1, rand_pkt());
                else
                    step($urandom_range(0, 2) != 0, rom_mem[m_ptr[0]][W-1:0]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_be_trace_replay_checker.md
BP_BE_TRACE_REPLAY_CHECKER -- requirements
Module: bp_be_trace_replay_checker

Interface
REQ-001 SHALL have parameter trace_ring_width_p, default 129, meaning commit-trace packet width.
REQ-002 SHALL have parameter rom_addr_width_p, default 10, meaning expected-trace ROM index width.
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock.
REQ-004 SHALL have port reset_n_i, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port data_i, input, trace_ring_width_p, meaning the committed trace packet; bit [128]=1 marks a store {1, addr[63:0], data[63:0]}; bit [128]=0 marks a register write {zeros, rd[4:0], result[63:0]}.
REQ-006 SHALL have port v_i, input, 1, meaning data_i is valid.
REQ-007 SHALL have port ready_o, output, 1, meaning the checker accepts data_i this cycle.
REQ-008 SHALL have port rom_addr_o, output, rom_addr_width_p, meaning the expected-trace ROM read index.
REQ-009 SHALL have port rom_data_i, input, trace_ring_width_p+1, meaning {eot, expected packet}, returned one cycle after rom_addr_o is presented.
REQ-010 SHALL have port done_o, output, 1, meaning the end-of-trace entry was reached with no error.
REQ-011 SHALL have port error_o, output, 1, meaning a sticky failure.
REQ-012 SHALL have port err_code_o, output, 2, meaning 00 none, 01 mismatch, 10 overflow.
REQ-013 SHALL have port count_o, output, rom_addr_width_p, meaning packets matched so far, equal to the index of the failing entry on error.
REQ-014 SHALL have port err_data_o, output, trace_ring_width_p, meaning the received packet that caused the mismatch.

Function
REQ-015 SHALL implement an FSM with states e_reset, e_prime, e_run, e_done and e_error.
REQ-016 e_reset SHALL go to e_prime on the first cycle after reset deassertion; e_prime SHALL go to e_run after one cycle, once ROM entry 0 is valid.
REQ-017 ready_o SHALL be 1 in e_run, e_done and e_error, and 0 otherwise; in e_done and e_error, accepted packets are discarded.
REQ-018 A packet SHALL be accepted when v_i & ready_o.
REQ-019 rom_addr_o SHALL be combinational: ptr_r+1 when a packet is accepted in e_run, otherwise ptr_r, so that one packet per cycle is checked with no bubbles.
REQ-020 If rom_data_i eot=1 while in e_run, the FSM SHALL enter e_done on the next cycle; the eot entry SHALL never be compared.
REQ-021 An accepted packet whose data_i equals rom_data_i[trace_ring_width_p-1:0] SHALL increment ptr_r and count_o by 1.
REQ-022 On an accepted packet that does not match, the checker SHALL enter e_error, set err_code_o=01, capture data_i into err_data_o, and leave count_o unchanged.
REQ-023 When a matching packet is accepted at ptr_r = 2^rom_addr_width_p-1, the checker SHALL enter e_error with err_code_o=10 and SHALL NOT wrap ptr_r.
REQ-024 The comparison SHALL be an exact full-width equality, with no masking.
REQ-025 error_o, err_code_o, err_data_o and done_o SHALL hold until reset.
REQ-026 v_i asserted while in e_reset or e_prime SHALL be ignored, since ready_o=0 in those states.

Reset
REQ-027 Asynchronous assertion of reset_n_i SHALL force state=e_reset, ptr_r=0, count_o=0, done_o=0, error_o=0, err_code_o=00, err_data_o=0, ready_o=0 and rom_addr_o=0, including when reset is asserted mid-run.
REQ-028 Deassertion of reset_n_i SHALL restart checking from ROM entry 0.

Structure
REQ-029 The state enum bp_be_trace_chk_state_e and the err_code constants SHALL reside in bp_be_pkg.
REQ-030 The trace ROM SHALL be external; the checker SHALL contain no sub-modules other than an optional bsg_dff_reset-style register for the capture fields.

Verification
REQ-031 Reset, then a ROM of 3 register packets plus eot; send 3 matching packets back-to-back -> count_o=3, done_o=1 on the cycle after the third accept, error_o=0.
REQ-032 Store packet {1, 0x8000_0000, 0xDEAD} expected, but data 0xBEEF is sent as the second packet -> error_o=1, err_code_o=01, count_o=1, err_data_o holds the 0xBEEF packet.
REQ-033 v_i toggling 1,0,1,0 over 4 matching entries -> rom_addr_o advances only on accept cycles; count_o=4.
REQ-034 rom_addr_width_p=2 with no eot and 4 matching packets -> err_code_o=10 after the 4th accept; ptr_r stays at 3.
REQ-035 reset_n_i pulsed low after 2 matches -> all outputs return to 0 immediately; the same trace replayed from entry 0 reaches done_o=1.
REQ-036 v_i held high during e_reset and e_prime -> no accept, ready_o=0, count_o=0.
